// File: rtl/tile_addr_responder.sv
// Address responder for a tiled AGU: issues bank A/B reads and bank C writes,
// and returns read data in acceptance order through a small response FIFO.
module tile_addr_responder #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_id,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              mem_a_en,
   output logic [ADDR_W-1:0] mem_a_addr,
   input  logic [DATA_W-1:0] mem_a_rdata,
   output logic              mem_b_en,
   output logic [ADDR_W-1:0] mem_b_addr,
   input  logic [DATA_W-1:0] mem_b_rdata,
   output logic              mem_c_we,
   output logic [ADDR_W-1:0] mem_c_addr,
   output logic [DATA_W-1:0] mem_c_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [1:0]        rsp_id,
   output logic              err_invalid,
   output logic              busy
);

   typedef enum logic [1:0] {
      MAT_A       = 2'd0,
      MAT_B       = 2'd1,
      MAT_C       = 2'd2,
      MAT_INVALID = 2'd3
   } matrix_id_t;

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   matrix_id_t        fifo_id   [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     fifo_count;
   logic [CW-1:0]     occupancy;
   logic              inflight_valid;
   matrix_id_t        inflight_id;
   matrix_id_t        req_kind;
   logic              accept;
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] push_data;

   assign req_kind = matrix_id_t'(req_id);

   // The outstanding read holds a FIFO slot in advance, so its push always fits.
   assign occupancy = fifo_count + CW'(inflight_valid);
   assign req_ready = rst_n && (occupancy < DEPTH_C);
   assign accept    = req_valid && req_ready;

   assign mem_a_en    = accept && (req_kind == MAT_A);
   assign mem_b_en    = accept && (req_kind == MAT_B);
   assign mem_c_we    = accept && (req_kind == MAT_C);
   assign mem_a_addr  = req_addr;
   assign mem_b_addr  = req_addr;
   assign mem_c_addr  = req_addr;
   assign mem_c_wdata = req_wdata;

   assign push      = inflight_valid;
   assign push_data = (inflight_id == MAT_A) ? mem_a_rdata : mem_b_rdata;
   assign rsp_valid = (fifo_count != '0);
   assign pop       = rsp_valid && rsp_ready;

   // Head is masked while empty so the outputs read zero / MAT_A in and after reset.
   assign rsp_data = rsp_valid ? fifo_data[rd_ptr] : '0;
   assign rsp_id   = rsp_valid ? fifo_id[rd_ptr] : MAT_A;
   assign busy     = inflight_valid || rsp_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_valid <= 1'b0;
         inflight_id    <= MAT_A;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fifo_count     <= '0;
         err_invalid    <= 1'b0;
      end else begin
         inflight_valid <= mem_a_en || mem_b_en;
         if (mem_a_en || mem_b_en) begin
            inflight_id <= req_kind;
         end
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
         if (accept && (req_kind == MAT_INVALID)) begin
            err_invalid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= push_data;
         fifo_id[wr_ptr]   <= inflight_id;
      end
   end

endmodule

// File: tb/tb_tile_addr_responder.sv
// Scoreboard bench for tile_addr_responder: stimulus queues expected responses,
// a negedge monitor pops and compares them as the DUT delivers responses.
module tb_tile_addr_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [9:0]  req_addr;
   logic [1:0]  req_id;
   logic [63:0] req_wdata;
   logic        mem_a_en, mem_b_en, mem_c_we;
   logic [9:0]  mem_a_addr, mem_b_addr, mem_c_addr;
   logic [63:0] mem_a_rdata, mem_b_rdata, mem_c_wdata;
   logic        rsp_valid, rsp_ready;
   logic [63:0] rsp_data;
   logic [1:0]  rsp_id;
   logic        err_invalid, busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [63:0] data;
      logic [1:0]  id;
   } exp_t;

   exp_t exp_q[$];
   int   pop_cycles[$];

   always #5 clk = ~clk;

   tile_addr_responder #(.ADDR_W(10), .DATA_W(64), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_id(req_id), .req_wdata(req_wdata),
      .mem_a_en(mem_a_en), .mem_a_addr(mem_a_addr), .mem_a_rdata(mem_a_rdata),
      .mem_b_en(mem_b_en), .mem_b_addr(mem_b_addr), .mem_b_rdata(mem_b_rdata),
      .mem_c_we(mem_c_we), .mem_c_addr(mem_c_addr), .mem_c_wdata(mem_c_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_id(rsp_id), .err_invalid(err_invalid), .busy(busy)
   );

   // Bank contents: A[5] = 0xAAAA, otherwise A[i] = 0xA0000000+i, B[i] = 0xB0000000+i.
   always @(posedge clk) begin
      if (mem_a_en) mem_a_rdata <= (mem_a_addr == 10'd5) ? 64'hAAAA : 64'hA000_0000 + 64'(mem_a_addr);
      if (mem_b_en) mem_b_rdata <= 64'hB000_0000 + 64'(mem_b_addr);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   logic        hold = 1'b0;
   logic [63:0] hold_data;
   logic [1:0]  hold_id;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         hold = 1'b0;
      end else begin
         if (hold) begin
            check("rsp_stable_data", rsp_data, hold_data);
            check("rsp_stable_id", 64'(rsp_id), 64'(hold_id));
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("rsp_data", rsp_data, e.data);
               check("rsp_id", 64'(rsp_id), 64'(e.id));
               pop_cycles.push_back(cyc);
            end
         end
         hold      = rsp_valid && !rsp_ready;
         hold_data = rsp_data;
         hold_id   = rsp_id;
      end
   end

   task automatic issue(input logic [1:0] id, input logic [9:0] addr,
                        input logic [63:0] wdata, input logic [63:0] exp);
      int n = 0;
      exp_t e;
      @(posedge clk); #1;
      req_valid = 1'b1; req_id = id; req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         check("issue_timeout", 64'd0, 64'd1);
      end else begin
         check("a_en", 64'(mem_a_en), 64'(id == 2'd0));
         check("b_en", 64'(mem_b_en), 64'(id == 2'd1));
         check("c_we", 64'(mem_c_we), 64'(id == 2'd2));
         if (id == 2'd0) check("a_addr", 64'(mem_a_addr), 64'(addr));
         if (id == 2'd1) check("b_addr", 64'(mem_b_addr), 64'(addr));
         if (id == 2'd2) begin
            check("c_addr", 64'(mem_c_addr), 64'(addr));
            check("c_wdata", mem_c_wdata, wdata);
         end
         if (id < 2'd2) begin
            e.data = exp; e.id = id;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", 64'(busy || exp_q.size() != 0), 64'd0);
   endtask

   initial begin
      logic [63:0] bexp [4];
      int acc;
      bexp = '{64'hB000_000A, 64'hB000_000B, 64'hB000_000C, 64'hB000_000D};
      rst_n = 1'b0; req_valid = 1'b1; req_id = 2'd0; req_addr = 10'd3;
      req_wdata = '0; rsp_ready = 1'b1;

      // Reset state, with a request held valid to show gating
      @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_a_en", 64'(mem_a_en), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_data", rsp_data, 64'd0);
      check("rst_rsp_id", 64'(rsp_id), 64'd0);
      check("rst_err", 64'(err_invalid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; req_valid = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 64'(req_ready), 64'd1);

      // Single read and its two-cycle latency
      issue(2'd0, 10'd5, '0, 64'hAAAA);
      idle();
      @(negedge clk);
      check("lat_n1_valid", 64'(rsp_valid), 64'd0);
      check("lat_n1_busy", 64'(busy), 64'd1);
      @(negedge clk);
      check("lat_n2_valid", 64'(rsp_valid), 64'd1);
      drain();

      // Write produces no response
      issue(2'd2, 10'd7, 64'h1234, '0);
      idle();
      repeat (3) @(negedge clk);
      check("write_no_rsp", 64'(rsp_valid), 64'd0);

      // Backpressure: six attempts, four accepted
      rsp_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         req_valid = 1'b1; req_id = 2'd1; req_addr = 10'(10 + acc);
         @(negedge clk);
         if (req_ready) begin
            exp_t e;
            e.data = bexp[acc]; e.id = 2'd1;
            exp_q.push_back(e);
            acc++;
         end
      end
      idle();
      check("bp_accepted", 64'(acc), 64'd4);
      repeat (3) @(negedge clk);
      check("bp_full_ready", 64'(req_ready), 64'd0);
      check("bp_full_valid", 64'(rsp_valid), 64'd1);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      drain();
      check("bp_ready_after", 64'(req_ready), 64'd1);

      // Interleaved A/B, one response per cycle
      pop_cycles.delete();
      issue(2'd0, 10'd0, '0, 64'hA000_0000);
      issue(2'd1, 10'd0, '0, 64'hB000_0000);
      issue(2'd0, 10'd1, '0, 64'hA000_0001);
      issue(2'd1, 10'd1, '0, 64'hB000_0001);
      idle();
      drain();
      check("il_count", 64'(pop_cycles.size()), 64'd4);
      for (int i = 1; i < pop_cycles.size(); i++)
         check("il_spacing", 64'(pop_cycles[i] - pop_cycles[i-1]), 64'd1);

      // Invalid request sets the sticky flag; later reads still work
      issue(2'd3, 10'd9, '0, '0);
      check("inv_err_before", 64'(err_invalid), 64'd0);
      idle();
      @(negedge clk);
      check("inv_err_after", 64'(err_invalid), 64'd1);
      check("inv_no_rsp", 64'(rsp_valid), 64'd0);
      issue(2'd0, 10'd5, '0, 64'hAAAA);
      idle();
      drain();
      check("inv_err_sticky", 64'(err_invalid), 64'd1);

      // Reset with three queued and one in flight
      rsp_ready = 1'b0;
      issue(2'd0, 10'd1, '0, 64'hA000_0001);
      issue(2'd0, 10'd2, '0, 64'hA000_0002);
      issue(2'd0, 10'd3, '0, 64'hA000_0003);
      issue(2'd0, 10'd4, '0, 64'hA000_0004);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("mid_busy", 64'(busy), 64'd1);
      check("mid_ready", 64'(req_ready), 64'd0);
      check("mid_valid", 64'(rsp_valid), 64'd1);
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("mrst_valid", 64'(rsp_valid), 64'd0);
      check("mrst_busy", 64'(busy), 64'd0);
      check("mrst_err", 64'(err_invalid), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; rsp_ready = 1'b1;
      repeat (5) @(negedge clk);
      check("mrst_no_stale", 64'(rsp_valid), 64'd0);
      check("mrst_ready", 64'(req_ready), 64'd1);

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tile_addr_responder.md
TILE_ADDR_RESPONDER -- requirements
Module: tile_addr_responder

Interface
REQ-001 Parameter ADDR_W, default 10, word address width of each tile bank.
REQ-002 Parameter DATA_W, default 64, data word width.
REQ-003 Parameter FIFO_DEPTH, default 4, response FIFO entries; power of two, at least 2.
REQ-004 clk  in  1  single clock; all state is updated on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  1  address request from the tiled AGU is valid.
REQ-007 req_ready  out  1  responder accepts the request this cycle.
REQ-008 req_addr  in  ADDR_W  word address within the bank selected by req_id.
REQ-009 req_id  in  2  matrix_id_t: MAT_A=0, MAT_B=1, MAT_C=2, MAT_INVALID=3.
REQ-010 req_wdata  in  DATA_W  write data, used only when req_id=MAT_C.
REQ-011 mem_a_en / mem_b_en  out  1  bank A / bank B read enable.
REQ-012 mem_a_addr / mem_b_addr  out  ADDR_W  bank A / bank B read address.
REQ-013 mem_a_rdata / mem_b_rdata  in  DATA_W  read data, valid exactly 1 cycle after the enable.
REQ-014 mem_c_we  out  1  bank C write enable.
REQ-015 mem_c_addr  out  ADDR_W  bank C write address.
REQ-016 mem_c_wdata  out  DATA_W  bank C write data.
REQ-017 rsp_valid  out  1  read response is available.
REQ-018 rsp_ready  in  1  consumer takes the response.
REQ-019 rsp_data  out  DATA_W  read data.
REQ-020 rsp_id  out  2  matrix_id_t of the originating request.
REQ-021 err_invalid  out  1  sticky flag: a MAT_INVALID request was accepted.
REQ-022 busy  out  1  read in flight or FIFO not empty.

Function
REQ-023 A request is accepted when req_valid and req_ready are both 1.
- Accepted MAT_A/MAT_B request: mem_x_en=1 and mem_x_addr=req_addr in the same cycle (combinational from the handshake).
- Enables are 0 in all other cycles.
REQ-024 The cycle after a MAT_A/MAT_B read, the selected bank's rdata and the id are pushed into the response FIFO.
- One in-flight register (valid, id) tracks the outstanding read.
REQ-025 Accepted MAT_C request: mem_c_we=1, mem_c_addr=req_addr, mem_c_wdata=req_wdata in the same cycle; no response is generated.
REQ-026 Accepted MAT_INVALID request: no memory access and no response; err_invalid is set to 1 on the next edge and holds until reset.
REQ-027 req_ready = (fifo_count + inflight_valid) < FIFO_DEPTH, where fifo_count is registered.
- This reservation guarantees a FIFO push is never dropped.
- req_ready is independent of req_valid and req_id.
REQ-028 Response FIFO:
- Strict order of acceptance, preserving interleaved A/B ordering.
- rsp_valid = fifo not empty; rsp_data and rsp_id are driven from the head entry.
- Pop occurs on rsp_valid && rsp_ready.
REQ-029 Minimum read latency: accept in cycle N -> rsp_valid=1 in cycle N+2. There is no bypass path.
REQ-030 Simultaneous push and pop: allowed in any state, including full; fifo_count is unchanged.
REQ-031 Pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.
REQ-032 Once rsp_valid is asserted, rsp_data and rsp_id stay stable until popped.
REQ-033 Sustained throughput: one request per cycle while rsp_ready=1.
REQ-034 busy = inflight_valid or fifo_count != 0.

Reset
REQ-035 While rst_n=0:
- req_ready=0.
- mem_a_en, mem_b_en, mem_c_we = 0.
- rsp_valid=0, rsp_data=0, rsp_id=MAT_A.
- err_invalid=0, busy=0.
- FIFO pointers, count and in-flight register are cleared.
REQ-036 Reset asserted mid-operation discards in-flight reads and all queued responses.
- No response is emitted after rst_n is released.
REQ-037 On the first cycle after rst_n deasserts, req_ready=1.

Verification
REQ-038 Single read: A-bank addr 5 holds 0xAAAA -> accept MAT_A addr 5 at cycle N, mem_a_en=1 at N, rsp_valid=1, rsp_data=0xAAAA, rsp_id=0 at N+2.
REQ-039 Write: MAT_C addr 7, wdata 0x1234 -> mem_c_we=1, addr 7, data 0x1234 in the same cycle; rsp_valid stays 0.
REQ-040 Backpressure: rsp_ready=0 with 6 back-to-back MAT_B reads -> exactly 4 accepted, then req_ready=0; releasing rsp_ready drains 4 responses in order, then req_ready=1.
REQ-041 Interleave: A0, B0, A1, B1 back-to-back with rsp_ready=1 -> responses in the same order with rsp_id 0,1,0,1; one response per cycle.
REQ-042 Invalid: MAT_INVALID request -> accepted, no enables asserted, err_invalid=1 from the next cycle; a following MAT_A read still completes normally.
REQ-043 Reset mid-stream: 3 responses queued and 1 in flight, then rst_n pulsed low -> rsp_valid=0, busy=0, err_invalid=0; no stale response after release.
